sbinit_fsm: RTL and testbench

- Link-training sideband initialisation stage (SBINIT), directly upstream of MBINIT in the LTSM.
- Exchanges the SBINIT out-of-reset and done request/response messages with the link partner over the sideband message interface.
- On success asserts SBINIT_done_o, which the LTSM uses to raise MBINIT's enable_i. On an 8 ms stall it flags a timeout for the LTSM to route to TRAINERROR.

---
 rtl/sbinit_fsm.sv | 172 +++++++++++++++++
 tb/tb_sbinit_fsm.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbinit_fsm.sv
// SBINIT link-training stage: trades out-of-reset and done request/response messages
// with the link partner over sideband, then reports done, or timeout after a stall.
package SB_codex_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] msg_info;
        logic [31:0] data;
    } SB_msg_t;

    localparam logic [7:0] SBINIT_OUT_OF_RESET = 8'h91;
    localparam logic [7:0] SBINIT_DONE_REQ     = 8'h95;
    localparam logic [7:0] SBINIT_DONE_RESP    = 8'h9A;
endpackage

// Handshake: an RX message is consumed in every cycle where RX_msg_req_o && RX_msg_valid_i;
// TX_msg_valid_o is a one-cycle pulse per message with no backpressure from the TX side.
module sbinit_fsm
    import SB_codex_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int RESEND_CYCLES  = 100
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       enable_i,
    output SB_msg_t    TX_msg_o,
    output logic       TX_msg_valid_o,
    input  SB_msg_t    RX_msg_i,
    input  logic       RX_msg_valid_i,
    output logic       RX_msg_req_o,
    output logic       SBINIT_done_o,
    output logic       SBINIT_timeout_o,
    output logic [2:0] state_dbg
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RS_W = $clog2(RESEND_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESEND_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OOR     = 3'd1,
        DONE_HS = 3'd2,
        DONE    = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic [RS_W-1:0] rs_cnt_q, rs_cnt_d;
    logic            req_sent_q, req_sent_d;
    logic            resp_pend_q, resp_pend_d;
    logic            sent_resp_q, sent_resp_d;
    logic            got_resp_q, got_resp_d;
    logic            done_q, done_d;
    logic            tx_valid;
    logic [7:0]      tx_op;
    logic            rx_fire;
    logic [7:0]      rx_op;
    logic            timeout_hit;
    logic            rx_fields_unused;

    assign RX_msg_req_o     = enable_i && (state_q == OOR || state_q == DONE_HS);
    assign rx_fire          = RX_msg_req_o && RX_msg_valid_i;
    assign rx_op            = RX_msg_i.opcode;
    assign rx_fields_unused = ^{RX_msg_i.msg_info, RX_msg_i.data};
    assign timeout_hit      = (to_cnt_q == TO_LAST);
    assign to_cnt_inc       = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            to_cnt_q    <= '0;
            rs_cnt_q    <= '0;
            req_sent_q  <= 1'b0;
            resp_pend_q <= 1'b0;
            sent_resp_q <= 1'b0;
            got_resp_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            rs_cnt_q    <= rs_cnt_d;
            req_sent_q  <= req_sent_d;
            resp_pend_q <= resp_pend_d;
            sent_resp_q <= sent_resp_d;
            got_resp_q  <= got_resp_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        rs_cnt_d    = rs_cnt_q;
        req_sent_d  = req_sent_q;
        resp_pend_d = resp_pend_q;
        sent_resp_d = sent_resp_q;
        got_resp_d  = got_resp_q;
        done_d      = 1'b0;
        tx_valid    = 1'b0;
        tx_op       = 8'h00;

        case (state_q)
            IDLE: begin
                to_cnt_d    = '0;
                rs_cnt_d    = '0;
                req_sent_d  = 1'b0;
                resp_pend_d = 1'b0;
                sent_resp_d = 1'b0;
                got_resp_d  = 1'b0;
                if (enable_i) state_d = OOR;
            end
            OOR: begin
                // The resend slot fires even when the partner's OOR lands in the same cycle.
                if (rs_cnt_q == '0) begin
                    tx_valid = 1'b1;
                    tx_op    = SBINIT_OUT_OF_RESET;
                end
                rs_cnt_d = (rs_cnt_q == RS_LAST) ? '0 : rs_cnt_q + RS_W'(1);
                to_cnt_d = to_cnt_inc;
                if (timeout_hit) state_d = TIMEOUT;
                else if (rx_fire && rx_op == SBINIT_OUT_OF_RESET) state_d = DONE_HS;
            end
            DONE_HS: begin
                if (!req_sent_q) begin
                    tx_valid   = 1'b1;
                    tx_op      = SBINIT_DONE_REQ;
                    req_sent_d = 1'b1;
                end else if (resp_pend_q) begin
                    tx_valid    = 1'b1;
                    tx_op       = SBINIT_DONE_RESP;
                    resp_pend_d = 1'b0;
                    sent_resp_d = 1'b1;
                end
                // A request consumed while the previous answer goes out re-arms the pending flag.
                if (rx_fire && rx_op == SBINIT_DONE_REQ)  resp_pend_d = 1'b1;
                if (rx_fire && rx_op == SBINIT_DONE_RESP) got_resp_d  = 1'b1;
                to_cnt_d = to_cnt_inc;
                if (timeout_hit) state_d = TIMEOUT;
                else if (got_resp_q && sent_resp_q) state_d = DONE;
            end
            DONE:    done_d = 1'b1;
            TIMEOUT: ;
            default: state_d = IDLE;
        endcase

        if (!enable_i) begin
            state_d     = IDLE;
            to_cnt_d    = '0;
            rs_cnt_d    = '0;
            req_sent_d  = 1'b0;
            resp_pend_d = 1'b0;
            sent_resp_d = 1'b0;
            got_resp_d  = 1'b0;
            done_d      = 1'b0;
            tx_valid    = 1'b0;
            tx_op       = 8'h00;
        end
    end

    always_comb begin
        TX_msg_o        = '0;
        TX_msg_o.opcode = tx_op;
    end

    assign TX_msg_valid_o   = tx_valid;
    assign SBINIT_done_o    = done_q;
    assign SBINIT_timeout_o = (state_q == TIMEOUT);
    assign state_dbg        = state_q;
endmodule

// File: tb/tb_sbinit_fsm.sv
// Self-checking bench for sbinit_fsm: timestamp-based model compared every cycle,
// plus hand-computed TX/done/timeout event lists per directed scenario.
module tb_sbinit_fsm;
  import SB_codex_pkg::*;

  localparam int TO = 1000;
  localparam int RS = 16;
  localparam logic [7:0] EV_DONE = 8'hFE;
  localparam logic [7:0] EV_TO   = 8'hFF;
  localparam logic [7:0] OP_OOR  = SBINIT_OUT_OF_RESET;
  localparam logic [7:0] OP_REQ  = SBINIT_DONE_REQ;
  localparam logic [7:0] OP_RESP = SBINIT_DONE_RESP;

  // clock/reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  SB_msg_t tx_msg, rx_msg;
  logic tx_valid, rx_valid, rx_req, done, timeout;
  logic [2:0] state_dbg;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sbinit_fsm #(.TIMEOUT_CYCLES(TO), .RESEND_CYCLES(RS)) dut (
    .clk_100MHz      (clk),
    .reset           (rst_n),
    .enable_i        (en),
    .TX_msg_o        (tx_msg),
    .TX_msg_valid_o  (tx_valid),
    .RX_msg_i        (rx_msg),
    .RX_msg_valid_i  (rx_valid),
    .RX_msg_req_o    (rx_req),
    .SBINIT_done_o   (done),
    .SBINIT_timeout_o(timeout),
    .state_dbg       (state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass = 0;
  int t0 = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  function automatic logic [31:0] ev(input logic [7:0] op, input int rel);
    return {op, 24'(rel)};
  endfunction

  task automatic check_events(input string name);
    chk({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_ev%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // model: each attempt is described by the absolute cycles at which its milestones happen
  int m_oor, m_hs, m_fin, m_to, m_req_rx, m_resp_tx, m_got, m_first_resp;
  bit prev_done, prev_to;

  function automatic void model_clear();
    m_oor = -1; m_hs = -1; m_fin = -1; m_to = -1;
    m_req_rx = -1; m_resp_tx = -1; m_got = -1; m_first_resp = -1;
  endfunction

  initial model_clear();

  always @(negedge clk) begin
    int c;
    bit idle, to_now, fin_now, in_hs, in_oor, e_req, e_done, consumed;
    logic [7:0] e_op;
    SB_msg_t e_msg;
    c = cyc;
    if (!rst_n) begin
      chk($sformatf("reset_outputs@%0d", c), {4'b0, tx_msg, tx_valid, rx_req, done, timeout}, 64'd0);
      model_clear();
      prev_done = 1'b0;
      prev_to = 1'b0;
    end else begin
      idle    = (m_oor < 0);
      to_now  = (m_to >= 0 && c >= m_to);
      fin_now = (m_fin >= 0 && c >= m_fin);
      in_hs   = !idle && m_hs >= 0 && c >= m_hs && !to_now && !fin_now;
      in_oor  = !idle && (m_hs < 0 || c < m_hs) && !to_now;
      e_req   = en && (in_oor || in_hs);
      e_op    = 8'h00;
      if (en && in_oor && ((c - m_oor) % RS == 0)) e_op = OP_OOR;
      else if (en && in_hs && c == m_hs) e_op = OP_REQ;
      else if (en && in_hs && m_req_rx >= 0 && m_req_rx < c && m_req_rx >= m_resp_tx) e_op = OP_RESP;
      e_done = fin_now && (c >= m_fin + 1);
      e_msg = '0;
      e_msg.opcode = e_op;
      chk($sformatf("cycle_rel%0d", c - t0), {4'b0, tx_msg, tx_valid, rx_req, done, timeout},
          {4'b0, e_msg, (e_op != 8'h00), e_req, e_done, to_now});

      if (tx_valid) got_q.push_back(ev(tx_msg.opcode, c - t0));
      if (done && !prev_done) got_q.push_back(ev(EV_DONE, c - t0));
      if (timeout && !prev_to) got_q.push_back(ev(EV_TO, c - t0));
      prev_done = done;
      prev_to = timeout;

      if (!en) begin
        if (!idle) model_clear();
      end else if (idle) begin
        m_oor = c + 1;
      end else begin
        consumed = e_req && rx_valid;
        if (e_op == OP_RESP) begin
          m_resp_tx = c;
          if (m_first_resp < 0) m_first_resp = c;
        end
        if (in_oor) begin
          if (c - m_oor == TO - 1) m_to = c + 1;
          else if (consumed && rx_msg.opcode == OP_OOR) m_hs = c + 1;
        end else if (in_hs) begin
          if (consumed && rx_msg.opcode == OP_REQ) m_req_rx = c;
          if (consumed && rx_msg.opcode == OP_RESP && m_got < 0) m_got = c;
          if (c - m_oor == TO - 1) m_to = c + 1;
          else if (m_got >= 0 && m_got < c && m_first_resp >= 0 && m_first_resp < c) m_fin = c + 1;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_msg = '0;
  endtask

  task automatic goto(input int r);
    while (cyc - t0 < r) tick();
  endtask

  task automatic inject(input int r, input logic [7:0] op);
    goto(r);
    rx_valid = 1'b1;
    rx_msg = '0;
    rx_msg.opcode = op;
  endtask

  task automatic start();
    tick();
    en = 1'b1;
    t0 = cyc;
  endtask

  task automatic stop(input int n);
    tick();
    en = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rx_valid = 1'b0;
    rx_msg = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    // partner silent: resends every 16 cycles until the timeout
    start();
    goto(1010);
    stop(3);
    for (int k = 0; k < 63; k++) exp_q.push_back(ev(OP_OOR, 1 + 16 * k));
    exp_q.push_back(ev(EV_TO, 1001));
    check_events("silent");

    // partner OOR after the third resend, then DONE_REQ and DONE_RESP
    start();
    inject(34, OP_OOR);
    inject(40, OP_REQ);
    inject(45, OP_RESP);
    goto(55);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_OOR, 17), ev(OP_OOR, 33), ev(OP_REQ, 35),
              ev(OP_RESP, 41), ev(EV_DONE, 48)};
    check_events("normal");

    // OOR on a resend slot, DONE_REQ on entry, repeated DONE_REQ, unknown opcode
    start();
    inject(1, OP_OOR);
    inject(2, OP_REQ);
    inject(5, OP_REQ);
    inject(7, 8'h55);
    inject(8, OP_RESP);
    goto(16);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_REQ, 2), ev(OP_RESP, 3), ev(OP_RESP, 6), ev(EV_DONE, 11)};
    check_events("entry_req");

    // partner DONE_RESP before its DONE_REQ, stray OOR in DONE_HS
    start();
    inject(17, OP_OOR);
    inject(19, OP_RESP);
    inject(20, OP_OOR);
    inject(25, OP_REQ);
    goto(35);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_OOR, 17), ev(OP_REQ, 18), ev(OP_RESP, 26), ev(EV_DONE, 29)};
    check_events("resp_first");

    // completion coinciding with timeout expiry: timeout wins
    start();
    inject(2, OP_OOR);
    inject(4, OP_REQ);
    inject(999, OP_RESP);
    goto(1006);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_REQ, 3), ev(OP_RESP, 5), ev(EV_TO, 1001)};
    check_events("to_race");

    // completion one cycle ahead of expiry: done wins
    start();
    inject(2, OP_OOR);
    inject(4, OP_REQ);
    inject(998, OP_RESP);
    goto(1006);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_REQ, 3), ev(OP_RESP, 5), ev(EV_DONE, 1001)};
    check_events("done_edge");

    // enable dropped in DONE_HS, then a fresh attempt
    start();
    inject(2, OP_OOR);
    goto(6);
    en = 1'b0;
    goto(7);
    chk("drop_outputs", {4'b0, tx_msg, tx_valid, rx_req, done, timeout}, 64'd0);
    goto(9);
    en = 1'b1;
    inject(27, OP_OOR);
    inject(29, OP_REQ);
    inject(31, OP_RESP);
    goto(40);
    stop(3);
    exp_q = '{ev(OP_OOR, 1), ev(OP_REQ, 3), ev(OP_OOR, 10), ev(OP_OOR, 26), ev(OP_REQ, 28),
              ev(OP_RESP, 30), ev(EV_DONE, 34)};
    check_events("restart");

    // async reset in the middle of an OOR pulse
    start();
    goto(17);
    chk("pre_reset_tx", 64'(tx_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {4'b0, tx_msg, tx_valid, rx_req, done, timeout}, 64'd0);
    en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    exp_q = '{ev(OP_OOR, 1)};
    check_events("async_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
